// File: rtl/phase_sequencer.sv
// Eight-phase instruction sequencer for a small accumulator CPU.
// Walks fetch/decode/execute phases, stalls on memory, halts on HLT and counts retired instructions.
module phase_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    input  logic        resume,
    output logic        sel,
    output logic        rd,
    output logic        wr,
    output logic        ld_ir,
    output logic        ld_ac,
    output logic        ld_pc,
    output logic        inc_pc,
    output logic        data_e,
    output logic        halt,
    output logic [1:0]  alu_op,
    output logic [2:0]  phase,
    output logic [15:0] retired
);

    localparam int unsigned OP_W      = 3;
    localparam int unsigned ALU_W     = 2;
    localparam int unsigned PHASE_W   = 3;
    localparam int unsigned RETIRED_W = 16;

    localparam logic [OP_W-1:0] OP_HLT = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA = 3'b101;
    localparam logic [OP_W-1:0] OP_STO = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP = 3'b111;

    localparam logic [PHASE_W-1:0] HALTED_PHASE = 3'd4;

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             is_aluop_c;
    logic             is_hlt_c;
    logic             is_skz_c;
    logic             is_sto_c;
    logic             is_jmp_c;
    logic             mem_wait_c;
    logic [ALU_W-1:0] alu_code_c;

    // Opcode decode
    always_comb begin
        is_aluop_c = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
        is_hlt_c   = (opcode == OP_HLT);
        is_skz_c   = (opcode == OP_SKZ);
        is_sto_c   = (opcode == OP_STO);
        is_jmp_c   = (opcode == OP_JMP);
        case (opcode)
            OP_AND:  alu_code_c = 2'b01;
            OP_XOR:  alu_code_c = 2'b10;
            OP_LDA:  alu_code_c = 2'b11;
            default: alu_code_c = 2'b00;
        endcase
    end

    // Phases that wait on memory: instruction read, operand read, store write
    always_comb begin
        mem_wait_c = 1'b0;
        case (state_q)
            S_INST_FETCH: mem_wait_c = 1'b1;
            S_OP_FETCH:   mem_wait_c = is_aluop_c;
            S_STORE:      mem_wait_c = is_sto_c;
            default:      mem_wait_c = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INST_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INST_ADDR:  state_d = S_INST_FETCH;
            S_INST_FETCH: state_d = mem_ready ? S_INST_LOAD : S_INST_FETCH;
            S_INST_LOAD:  state_d = S_IDLE;
            S_IDLE:       state_d = S_OP_ADDR;
            S_OP_ADDR:    state_d = is_hlt_c ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH:   state_d = (mem_wait_c && !mem_ready) ? S_OP_FETCH : S_ALU_OP;
            S_ALU_OP:     state_d = S_STORE;
            S_STORE:      state_d = (mem_wait_c && !mem_ready) ? S_STORE : S_INST_ADDR;
            S_HALTED:     state_d = resume ? S_OP_FETCH : S_HALTED;
            default:      state_d = S_INST_ADDR;
        endcase
    end

    // Datapath strobes decoded from the current phase and opcode
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = state_q[PHASE_W-1:0];
        case (state_q)
            S_INST_ADDR: begin
                sel = 1'b1;
            end
            S_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = is_hlt_c;
            end
            S_OP_FETCH: begin
                rd = is_aluop_c;
            end
            S_ALU_OP: begin
                rd     = is_aluop_c;
                inc_pc = is_skz_c && zero;
                ld_pc  = is_jmp_c;
                data_e = is_sto_c;
            end
            S_STORE: begin
                rd     = is_aluop_c;
                ld_ac  = is_aluop_c;
                ld_pc  = is_jmp_c;
                wr     = is_sto_c;
                data_e = is_sto_c;
            end
            S_HALTED: begin
                halt  = 1'b1;
                phase = HALTED_PHASE;
            end
            default: begin
                sel = 1'b1;
            end
        endcase
        alu_op = ld_ac ? alu_code_c : 2'b00;
    end

    // Retired-instruction counter, bumped on the 7 -> 0 wrap only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if ((state_q == S_STORE) && (state_d == S_INST_ADDR)) begin
            retired <= retired + RETIRED_W'(1);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: vector table, directed corner sequences and a
// randomized run checked against a rule-level reference model.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        resume;
    logic        sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [1:0]  alu_op;
    logic [2:0]  phase;
    logic [15:0] retired;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
        .ld_pc(ld_pc), .inc_pc(inc_pc), .data_e(data_e), .halt(halt),
        .alu_op(alu_op), .phase(phase), .retired(retired)
    );

    // {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}
    logic [8:0] dut_out;
    assign dut_out = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

    int total = 0;
    int bad   = 0;

    int          m_phase;
    bit          m_halted;
    logic [15:0] m_ret;

    logic [8:0]  s_out;
    logic [1:0]  s_alu;
    logic [2:0]  s_phase;

    bit watch_ld_ac = 1'b0;
    bit saw_ld_ac   = 1'b0;
    always @(posedge ld_ac) if (watch_ld_ac) saw_ld_ac = 1'b1;

    typedef struct {
        logic [2:0]  op;
        logic        z;
        logic        mr;
        logic [2:0]  ph;
        logic [8:0]  out;
        logic [1:0]  alu;
        logic [15:0] ret;
    } vec_t;
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_aluop(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd5);
    endfunction

    // Expected strobes straight from the per-phase rules
    function automatic logic [8:0] exp_out(input int ph, input bit hl, input logic [2:0] op, input logic z);
        logic [8:0] v;
        bit a;
        a = is_aluop(op);
        if (hl) return 9'b000000001;
        v[8] = (ph <= 3);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && a);
        v[6] = (ph == 7) && (op == 3'd6);
        v[5] = (ph == 2) || (ph == 3);
        v[4] = (ph == 7) && a;
        v[3] = (ph >= 6) && (op == 3'd7);
        v[2] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        v[1] = (ph >= 6) && (op == 3'd6);
        v[0] = (ph == 4) && (op == 3'd0);
        return v;
    endfunction

    function automatic logic [1:0] exp_alu(input int ph, input bit hl, input logic [2:0] op);
        if (!hl && ph == 7 && is_aluop(op)) return 2'(op - 3'd2);
        return 2'b00;
    endfunction

    task automatic model_step();
        bit stall;
        stall = (m_phase == 1) || (m_phase == 5 && is_aluop(opcode)) ||
                (m_phase == 7 && opcode == 3'd6);
        if (m_halted) begin
            if (resume) begin
                m_halted = 1'b0;
                m_phase  = 5;
            end
        end else if (stall && !mem_ready) begin
            m_phase = m_phase;
        end else if (m_phase == 4 && opcode == 3'd0) begin
            m_halted = 1'b1;
        end else begin
            if (m_phase == 7) m_ret = m_ret + 16'd1;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    // Called at a falling edge with inputs already set
    task automatic tick();
        #1;
        s_out   = dut_out;
        s_alu   = alu_op;
        s_phase = phase;
        check("phase",   32'(phase),   m_halted ? 32'd4 : 32'(m_phase));
        check("strobes", 32'(dut_out), 32'(exp_out(m_phase, m_halted, opcode, zero)));
        check("alu_op",  32'(alu_op),  32'(exp_alu(m_phase, m_halted, opcode)));
        check("retired", 32'(retired), 32'(m_ret));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_halted = 1'b0;
        m_ret    = 16'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"},   32'(phase),   32'd0);
        check({tag, "_strobes"}, 32'(dut_out), 32'h100);
        check({tag, "_alu"},     32'(alu_op),  32'd0);
        check({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    task automatic run_to_phase(input int p);
        mem_ready = 1'b1;
        resume    = 1'b0;
        for (int i = 0; i < 24 && !(m_phase == p && !m_halted); i++) tick();
        #1 check("reach_phase", 32'(phase), 32'(p));
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic z, input logic [2:0] ph,
                                input logic [8:0] out, input logic [1:0] alu, input logic [15:0] ret);
        vec_t v;
        v.op = op; v.z = z; v.mr = 1'b1; v.ph = ph; v.out = out; v.alu = alu; v.ret = ret;
        return v;
    endfunction

    initial begin
        int mask, n7, nw, nh, ni, stalls;
        logic [15:0] r0;
        logic [11:0] seq;
        bit done;

        tbl[0]  = mk(3'd2, 1'b0, 3'd0, 9'b100000000, 2'd0, 16'd0);
        tbl[1]  = mk(3'd2, 1'b1, 3'd1, 9'b110000000, 2'd0, 16'd0);
        tbl[2]  = mk(3'd2, 1'b0, 3'd2, 9'b110100000, 2'd0, 16'd0);
        tbl[3]  = mk(3'd2, 1'b1, 3'd3, 9'b110100000, 2'd0, 16'd0);
        tbl[4]  = mk(3'd2, 1'b0, 3'd4, 9'b000000100, 2'd0, 16'd0);
        tbl[5]  = mk(3'd2, 1'b1, 3'd5, 9'b010000000, 2'd0, 16'd0);
        tbl[6]  = mk(3'd2, 1'b1, 3'd6, 9'b010000000, 2'd0, 16'd0);
        tbl[7]  = mk(3'd2, 1'b0, 3'd7, 9'b010010000, 2'd0, 16'd0);
        tbl[8]  = mk(3'd7, 1'b0, 3'd0, 9'b100000000, 2'd0, 16'd1);
        tbl[9]  = mk(3'd7, 1'b0, 3'd1, 9'b110000000, 2'd0, 16'd1);
        tbl[10] = mk(3'd7, 1'b1, 3'd2, 9'b110100000, 2'd0, 16'd1);
        tbl[11] = mk(3'd7, 1'b0, 3'd3, 9'b110100000, 2'd0, 16'd1);
        tbl[12] = mk(3'd7, 1'b1, 3'd4, 9'b000000100, 2'd0, 16'd1);
        tbl[13] = mk(3'd7, 1'b0, 3'd5, 9'b000000000, 2'd0, 16'd1);
        tbl[14] = mk(3'd7, 1'b1, 3'd6, 9'b000001000, 2'd0, 16'd1);
        tbl[15] = mk(3'd7, 1'b0, 3'd7, 9'b000001000, 2'd0, 16'd1);
        tbl[16] = mk(3'd7, 1'b0, 3'd0, 9'b100000000, 2'd0, 16'd2);

        rst_n = 1'b1; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;

        // Vector table: ADD then JMP with memory always ready
        foreach (tbl[i]) begin
            opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].mr; resume = 1'b0;
            tick();
            check($sformatf("tbl%0d_phase", i),   32'(s_phase), 32'(tbl[i].ph));
            check($sformatf("tbl%0d_strobes", i), 32'(s_out),   32'(tbl[i].out));
            check($sformatf("tbl%0d_alu", i),     32'(s_alu),   32'(tbl[i].alu));
        end
        #1 check("tbl_retired_end", 32'(retired), 32'd2);

        // SKZ with zero=1 and zero=0
        for (int zz = 1; zz >= 0; zz--) begin
            run_to_phase(0);
            opcode = 3'd1; zero = 1'(zz); mask = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (s_out[2]) mask |= (1 << s_phase);
            end
            check($sformatf("skz_z%0d_inc_mask", zz), 32'(mask), zz ? 32'h50 : 32'h10);
        end

        // STO with three wait cycles in phase 7
        run_to_phase(0);
        opcode = 3'd6; r0 = retired; n7 = 0; nw = 0; stalls = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (m_phase == 7 && stalls < 3) begin mem_ready = 1'b0; stalls++; end
            else mem_ready = 1'b1;
            tick();
            if (s_phase == 3'd7) begin
                n7++;
                if (s_out[6] && s_out[1]) nw++;
                if (phase == 3'd0) done = 1'b1;
            end
        end
        check("sto_done", 32'(done), 32'd1);
        check("sto_phase7_cycles", 32'(n7), 32'd4);
        check("sto_wr_de_cycles", 32'(nw), 32'd4);
        check("sto_retired_delta", 32'(retired - r0), 32'd1);

        // HLT, resume on the tenth halted cycle
        run_to_phase(0);
        opcode = 3'd0;
        run_to_phase(4);
        nh = 0; ni = 0;
        for (int i = 0; i < 11; i++) begin
            resume = (i == 10);
            tick();
            if (s_out[0]) nh++;
            if (s_out[2]) ni++;
        end
        resume = 1'b0; seq = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq = {seq[8:0], s_phase};
        end
        check("hlt_halt_cycles", 32'(nh), 32'd11);
        check("hlt_inc_pc_cycles", 32'(ni), 32'd1);
        check("hlt_resume_phases", 32'(seq), 32'b101_110_111_000);

        // Resume outside HALTED must be ignored
        run_to_phase(1);
        opcode = 3'd2; resume = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        resume = 1'b0;
        check("resume_ignored_phase", 32'(s_phase), 32'd2);

        // Reset in phase 6 of LDA
        run_to_phase(0);
        opcode = 3'd5; watch_ld_ac = 1'b1; saw_ld_ac = 1'b0;
        run_to_phase(6);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("lda_async");
        @(posedge clk);
        #1 check_reset_outputs("lda_held");
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        tick();
        check("post_reset_first", 32'(s_phase), 32'd0);
        tick();
        check("post_reset_advance", 32'(s_phase), 32'd1);
        watch_ld_ac = 1'b0;
        check("lda_no_ld_ac", 32'(saw_ld_ac), 32'd0);

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            opcode    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            resume    = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
